// File: rtl/fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds everything, clear inserts a bubble
// but keeps the last PC+4.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_next,
    input  logic [XLEN-1:0] pc_plus4_next,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (stall) begin
            instr    <= instr;
            pc_plus4 <= pc_plus4;
            valid    <= valid;
        end else if (clear) begin
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else begin
            instr    <= instr_next;
            pc_plus4 <= pc_plus4_next;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, imem req/ready handshake and
// a one-word hold buffer for words that arrive while fetch is stalled.
//
// state | meaning
// REQ   | request outstanding at PC (idle for one cycle after reset)
// HELD  | word captured in hold_buf while StallF, no request
// DRAIN | redirect seen mid-request; finish handshake, then go to tgt
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcD,
    input  logic            JumpD,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic [XLEN-1:0] JumpTargetD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusy
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] tgt;
    logic            req_q;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            deliver;
    logic [XLEN-1:0] deliver_word;

    always_comb begin
        redirect     = (JumpD | PCSrcD) & ~StallD;
        target       = JumpD ? JumpTargetD : PCBranchD;
        pc_plus4     = pc + 32'd4;
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        if (state == REQ) begin
            deliver = req_q & imem_ready & ~StallF & ~redirect;
        end else if (state == HELD) begin
            deliver      = ~StallF & ~redirect;
            deliver_word = hold_buf;
        end
    end

    // req_q is low only in the first cycle after reset, so REQ ignores ready
    // until the request is actually visible to the memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            hold_buf <= '0;
            tgt      <= '0;
            req_q    <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    req_q <= 1'b1;
                    if (req_q) begin
                        if (imem_ready && redirect) begin
                            pc <= target;
                        end else if (redirect) begin
                            tgt   <= target;
                            state <= DRAIN;
                        end else if (imem_ready && !StallF) begin
                            pc <= pc_plus4;
                        end else if (imem_ready) begin
                            hold_buf <= imem_rdata;
                            state    <= HELD;
                            req_q    <= 1'b0;
                        end
                    end
                end
                HELD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                        req_q <= 1'b1;
                    end else if (!StallF) begin
                        pc    <= pc_plus4;
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A redirect landing on the completing cycle is the newest one.
                    if (imem_ready) begin
                        pc    <= redirect ? target : tgt;
                        state <= REQ;
                    end else if (redirect) begin
                        tgt <= target;
                    end
                end
                default: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign FetchBusy = ((state == REQ) && !(req_q && imem_ready)) || (state == DRAIN);

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clock        (clock),
        .reset        (reset),
        .stall        (StallD),
        .clear        (FlushD | redirect | ~deliver),
        .instr_next   (deliver_word),
        .pc_plus4_next(pc_plus4),
        .instr        (InstrD),
        .pc_plus4     (PCPlus4D),
        .valid        (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns its address as the word,
// IF/ID expectations go through a scoreboard queue popped after each edge.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, JumpTargetD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, FetchBusy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;
    exp_t sb[$];

    fetch_stage dut (
        .clock      (clock),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .PCBranchD  (PCBranchD),
        .JumpTargetD(JumpTargetD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusy  (FetchBusy)
    );

    always #5 clock = ~clock;
    assign imem_rdata = imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        e.valid = valid;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, InstrD, e.instr);
            chk({tag, "_pc4"}, PCPlus4D, e.pc4);
            chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, e.valid});
        end
    endtask

    task automatic fetch_port(input string tag, input logic req, input logic [31:0] addr,
                              input logic busy);
        #1;
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_busy"}, {31'd0, FetchBusy}, {31'd0, busy});
    endtask

    initial begin
        reset = 1'b0;
        {StallF, StallD, FlushD, PCSrcD, JumpD} = '0;
        PCBranchD   = '0;
        JumpTargetD = '0;
        imem_ready  = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);

        @(negedge clock);
        reset = 1'b1;
        push(32'h0, 32'h0, 1'b0);
        tick("start0");
        fetch_port("start0", 1'b1, 32'h0, 1'b0);
        push(32'h0, 32'h4, 1'b1);
        tick("seq0");
        fetch_port("seq0", 1'b1, 32'h4, 1'b0);
        push(32'h4, 32'h8, 1'b1);
        tick("seq4");

        // three wait states at PC=8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_port("wait8", 1'b1, 32'h8, 1'b1);
            push(32'h0, 32'h8, 1'b0);
            tick("bubble8");
        end
        imem_ready = 1'b1;
        push(32'h8, 32'hC, 1'b1);
        tick("seq8");

        // stall while word 0xC returns: captured, IF/ID frozen
        StallF = 1'b1;
        StallD = 1'b1;
        push(32'h8, 32'hC, 1'b1);
        tick("stall1");
        fetch_port("held", 1'b0, 32'hC, 1'b0);
        push(32'h8, 32'hC, 1'b1);
        tick("stall2");
        StallF = 1'b0;
        StallD = 1'b0;
        push(32'hC, 32'h10, 1'b1);
        tick("unheld");
        fetch_port("after_held", 1'b1, 32'h10, 1'b0);
        push(32'h10, 32'h14, 1'b1);
        tick("seq10");

        // branch while fetch at 0x14 waits two cycles
        imem_ready = 1'b0;
        PCSrcD     = 1'b1;
        PCBranchD  = 32'h100;
        push(32'h0, 32'h14, 1'b0);
        tick("br_req");
        PCSrcD = 1'b0;
        fetch_port("drain", 1'b1, 32'h14, 1'b1);
        push(32'h0, 32'h14, 1'b0);
        tick("br_wait");
        imem_ready = 1'b1;
        push(32'h0, 32'h14, 1'b0);
        tick("br_drop14");
        fetch_port("br_target", 1'b1, 32'h100, 1'b0);
        push(32'h100, 32'h104, 1'b1);
        tick("br_seq");

        // jump wins over branch
        JumpD       = 1'b1;
        PCSrcD      = 1'b1;
        JumpTargetD = 32'h200;
        PCBranchD   = 32'h300;
        push(32'h0, 32'h104, 1'b0);
        tick("jmp_req");
        JumpD  = 1'b0;
        PCSrcD = 1'b0;
        fetch_port("jmp_target", 1'b1, 32'h200, 1'b0);
        push(32'h200, 32'h204, 1'b1);
        tick("jmp_seq");

        // branch under StallD is ignored
        StallF = 1'b1;
        StallD = 1'b1;
        PCSrcD = 1'b1;
        push(32'h200, 32'h204, 1'b1);
        tick("br_stalled");
        StallF = 1'b0;
        StallD = 1'b0;
        PCSrcD = 1'b0;
        push(32'h204, 32'h208, 1'b1);
        tick("br_ignored");
        fetch_port("br_ignored", 1'b1, 32'h208, 1'b0);

        // flush inserts a bubble but fetch still advances
        FlushD = 1'b1;
        push(32'h0, 32'h208, 1'b0);
        tick("flush");
        FlushD = 1'b0;
        fetch_port("flush", 1'b1, 32'h20C, 1'b0);

        // enter DRAIN, then reset mid-cycle
        imem_ready = 1'b0;
        PCSrcD     = 1'b1;
        PCBranchD  = 32'h400;
        push(32'h0, 32'h208, 1'b0);
        tick("drain2");
        PCSrcD = 1'b0;
        fetch_port("drain2", 1'b1, 32'h20C, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_instr", InstrD, 32'h0);
        chk("arst_pc4", PCPlus4D, 32'h0);
        chk("arst_valid", {31'd0, ValidD}, 32'd0);

        @(negedge clock);
        reset      = 1'b1;
        imem_ready = 1'b1;
        push(32'h0, 32'h0, 1'b0);
        tick("restart0");
        fetch_port("restart0", 1'b1, 32'h0, 1'b0);
        push(32'h0, 32'h4, 1'b1);
        tick("restart_seq");
        fetch_port("restart_seq", 1'b1, 32'h4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and next-PC selection: sequential, branch from decode, or jump from decode.
- Fronts a variable-latency instruction memory through a req/ready handshake.
- Drives the IF/ID pipeline register (InstrD, PCPlus4D), honouring stall and flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID for bubbles.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit: hold PC / fetch.
- StallD  in  1  hazard unit: hold IF/ID.
- FlushD  in  1  hazard unit: load bubble into IF/ID.
- PCSrcD  in  1  branch taken, resolved in decode.
- JumpD  in  1  jump in decode.
- PCBranchD  in  32  branch target from decode.
- JumpTargetD  in  32  jump target from decode.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req is high until imem_ready.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- FetchBusy  out  1  to hazard unit: fetch cannot deliver this cycle.

Behaviour:
- Reset (async, reset=0): PC=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, hold buffer=0, redirect target=0. imem_req goes to 1 on the first cycle after reset is released.
- redirect = (JumpD | PCSrcD) & ~StallD. Target = JumpD ? JumpTargetD : PCBranchD; JumpD has priority. PCSrcD/JumpD are ignored while StallD=1.
- PC+4 is a 32-bit add; wrap is permitted (32'hFFFF_FFFC+4 = 0).
- State REQ: imem_req=1, imem_addr=PC.
  - ready & redirect: discard the word, PC<=target, stay in REQ.
  - ~ready & redirect: save target to tgt, go to DRAIN.
  - ready & ~StallF: deliver imem_rdata, PC<=PC+4, stay in REQ.
  - ready & StallF: buf<=imem_rdata, go to HELD.
  - ~ready: stay in REQ.
- State HELD: imem_req=0.
  - redirect: drop buf, PC<=target, go to REQ.
  - ~StallF: deliver buf, PC<=PC+4, go to REQ.
  - Otherwise stay in HELD.
- State DRAIN: imem_req=1 at the old PC (handshake must complete). A new redirect overwrites tgt.
  - ready: discard the word, PC<=tgt, go to REQ.
- FetchBusy = (REQ & ~imem_ready) | DRAIN.
- IF/ID update on each clock edge:
  - StallD=1: hold all IF/ID fields. This takes priority over everything else.
  - Else if FlushD | redirect | no delivery this cycle: InstrD=NOP_INSTR, ValidD=0, PCPlus4D unchanged.
  - Else: InstrD=delivered word, PCPlus4D=PC+4, ValidD=1.
- Latency: with zero-wait memory, the word fetched at PC appears in InstrD on the next edge. Throughput is one instruction per cycle.
- Reset mid-request: the FSM abandons the request immediately and imem_req drops asynchronously. The memory must tolerate an abandoned request.

Decomposition:
- Shared package fetch_pkg:
  - state enum {REQ, HELD, DRAIN}.
  - NOP_INSTR and RESET_PC defaults.
  - Width constant XLEN=32.
- One sub-module: if_id_reg, holding the IF/ID register with stall/clear/valid and an asynchronous active-low reset.
- The FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata = address -> imem_addr sequence 0,4,8; InstrD lags imem_addr by 1 cycle; PCPlus4D=InstrD+4; ValidD=1 from the second edge.
- imem_ready low 3 cycles at PC=8 -> imem_addr held at 8, FetchBusy=1 for those 3 cycles, 3 bubbles with ValidD=0, then InstrD=8.
- StallF=StallD=1 for 2 cycles while ready returns word at 0xC -> state HELD, imem_req=0, IF/ID unchanged; after release InstrD=0xC and next imem_addr=0x10 with no refetch.
- PCSrcD=1, PCBranchD=0x100 while the fetch at 0x14 is waiting 2 cycles -> imem_addr stays 0x14 until ready, the 0x14 word is never loaded into IF/ID, then imem_addr=0x100.
- JumpD=1 and PCSrcD=1 in the same cycle (JumpTargetD=0x200, PCBranchD=0x300) -> next fetch is 0x200. Separately, PCSrcD=1 while StallD=1 -> ignored.
- Assert reset mid-DRAIN -> outputs return to reset values immediately (asynchronously); after release, fetch restarts at RESET_PC.
